// File: rtl/sl_bus_arbiter.sv
// Round-robin arbiter for the shared slave output bus feeding the UART TX path.
// One frame-long grant at a time, with a high-priority class mask and a grant watchdog.
module sl_bus_arbiter #(
    parameter int NUM_DEV = 7,
    parameter int IDX_W   = 3,
    parameter int TIMEOUT = 65535,
    parameter int CNT_W   = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_DEV-1:0] req,
    input  logic [NUM_DEV-1:0] hp_mask,
    input  logic               tx_idle,
    output logic [NUM_DEV-1:0] grant,
    output logic [IDX_W-1:0]   grant_idx,
    output logic               busy,
    output logic               timeout_evt,
    output logic [IDX_W-1:0]   timeout_idx
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        GAP   = 2'd2
    } state_t;

    localparam bit               WDOG_EN  = (TIMEOUT != 0);
    localparam logic [CNT_W-1:0] CNT_LAST = WDOG_EN ? CNT_W'(TIMEOUT - 1) : '0;
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;

    state_t             state_q, state_d;
    logic [NUM_DEV-1:0] grant_q, grant_d;
    logic [IDX_W-1:0]   grantIdx_q, grantIdx_d;
    logic               busy_q, busy_d;
    logic               timeoutEvt_q, timeoutEvt_d;
    logic [IDX_W-1:0]   timeoutIdx_q, timeoutIdx_d;
    logic [IDX_W-1:0]   rrPtr_q, rrPtr_d;
    logic [NUM_DEV-1:0] lockout_q, lockout_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;

    logic [NUM_DEV-1:0] elig;
    logic [NUM_DEV-1:0] hpElig;
    logic [NUM_DEV-1:0] cand;
    logic [NUM_DEV-1:0] lockSet;
    logic               found;
    logic [IDX_W-1:0]   winIdx;

    // Index base+offs modulo NUM_DEV, for offs in 0..NUM_DEV.
    function automatic logic [IDX_W-1:0] wrapInc(input logic [IDX_W-1:0] base, input int offs);
        int sum;
        sum = int'(base) + offs;
        if (sum >= NUM_DEV) begin
            sum = sum - NUM_DEV;
        end
        return sum[IDX_W-1:0];
    endfunction

    assign elig   = req & ~lockout_q;
    assign hpElig = elig & hp_mask;
    assign cand   = (hpElig != '0) ? hpElig : elig;

    always_comb begin
        found  = 1'b0;
        winIdx = '0;
        for (int k = 0; k < NUM_DEV; k++) begin
            if (!found && cand[wrapInc(rrPtr_q, k)]) begin
                found  = 1'b1;
                winIdx = wrapInc(rrPtr_q, k);
            end
        end
    end

    always_comb begin
        state_d      = state_q;
        grant_d      = grant_q;
        grantIdx_d   = grantIdx_q;
        busy_d       = busy_q;
        timeoutEvt_d = 1'b0;
        timeoutIdx_d = timeoutIdx_q;
        rrPtr_d      = rrPtr_q;
        cnt_d        = cnt_q;
        lockSet      = '0;

        case (state_q)
            IDLE: begin
                grant_d = '0;
                busy_d  = 1'b0;
                if (tx_idle && found) begin
                    grant_d[winIdx] = 1'b1;
                    grantIdx_d      = winIdx;
                    busy_d          = 1'b1;
                    cnt_d           = '0;
                    rrPtr_d         = wrapInc(winIdx, 1);
                    state_d         = GRANT;
                end
            end
            GRANT: begin
                // A falling request takes precedence over a coincident watchdog expiry.
                if (!req[grantIdx_q]) begin
                    grant_d = '0;
                    busy_d  = 1'b0;
                    state_d = GAP;
                end else if (WDOG_EN && (cnt_q >= CNT_LAST)) begin
                    grant_d             = '0;
                    busy_d              = 1'b0;
                    timeoutEvt_d        = 1'b1;
                    timeoutIdx_d        = grantIdx_q;
                    lockSet[grantIdx_q] = 1'b1;
                    state_d             = GAP;
                end else if (cnt_q != CNT_MAX) begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            GAP: begin
                grant_d = '0;
                busy_d  = 1'b0;
                state_d = IDLE;
            end
            default: begin
                grant_d = '0;
                busy_d  = 1'b0;
                state_d = IDLE;
            end
        endcase
    end

    // A locked-out requester is released as soon as it drops its request.
    assign lockout_d = (lockout_q & req) | lockSet;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            grant_q      <= '0;
            grantIdx_q   <= '0;
            busy_q       <= 1'b0;
            timeoutEvt_q <= 1'b0;
            timeoutIdx_q <= '0;
            rrPtr_q      <= '0;
            lockout_q    <= '0;
            cnt_q        <= '0;
        end else begin
            state_q      <= state_d;
            grant_q      <= grant_d;
            grantIdx_q   <= grantIdx_d;
            busy_q       <= busy_d;
            timeoutEvt_q <= timeoutEvt_d;
            timeoutIdx_q <= timeoutIdx_d;
            rrPtr_q      <= rrPtr_d;
            lockout_q    <= lockout_d;
            cnt_q        <= cnt_d;
        end
    end

    assign grant       = grant_q;
    assign grant_idx   = grantIdx_q;
    assign busy        = busy_q;
    assign timeout_evt = timeoutEvt_q;
    assign timeout_idx = timeoutIdx_q;

    // Structural invariants of the grant outputs.
    aGrantOneHot: assert property (@(posedge clk) disable iff (rst) $onehot0(grant_q));
    aBusyMatches: assert property (@(posedge clk) disable iff (rst) busy_q == (|grant_q));
    aIdxMatches:  assert property (@(posedge clk) disable iff (rst) busy_q |-> grant_q[grantIdx_q]);

endmodule

// File: tb/tb_sl_bus_arbiter.sv
// Directed self-checking bench for sl_bus_arbiter: a cycle table plus hand-written
// sequences for round-robin, tx_idle gating, watchdog and mid-frame reset.
module tb_sl_bus_arbiter;

    logic       clk;
    logic       rst;
    logic [6:0] req;
    logic [6:0] hpMask;
    logic       txIdle;
    logic [6:0] grant;
    logic [2:0] grantIdx;
    logic       busy;
    logic       timeoutEvt;
    logic [2:0] timeoutIdx;

    int checks;
    int fails;

    typedef struct {
        logic [6:0] req;
        logic [6:0] hp;
        logic       tx;
        logic [6:0] expGrant;
        logic       expBusy;
        logic [2:0] expIdx;
    } vec_t;

    vec_t vecs[$];

    sl_bus_arbiter #(
        .NUM_DEV(7),
        .IDX_W  (3),
        .TIMEOUT(8),
        .CNT_W  (16)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .req        (req),
        .hp_mask    (hpMask),
        .tx_idle    (txIdle),
        .grant      (grant),
        .grant_idx  (grantIdx),
        .busy       (busy),
        .timeout_evt(timeoutEvt),
        .timeout_idx(timeoutIdx)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic void addVec(input logic [6:0] r, input logic [6:0] h, input logic t,
                                   input logic [6:0] g, input logic b, input logic [2:0] i);
        vec_t v;
        v.req      = r;
        v.hp       = h;
        v.tx       = t;
        v.expGrant = g;
        v.expBusy  = b;
        v.expIdx   = i;
        vecs.push_back(v);
    endfunction

    task automatic applyStimulus(input logic [6:0] r, input logic [6:0] h, input logic t);
        req    = r;
        hpMask = h;
        txIdle = t;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // grant_idx is only meaningful while busy (or straight out of reset), hence cmpIdx.
    task automatic checkOutput(input string name, input logic [6:0] expGrant, input logic expBusy,
                               input logic cmpIdx, input logic [2:0] expIdx,
                               input logic expEvt, input logic [2:0] expTidx);
        checks++;
        if (grant !== expGrant || busy !== expBusy || (cmpIdx && grantIdx !== expIdx) ||
            timeoutEvt !== expEvt || timeoutIdx !== expTidx) begin
            fails++;
            $display("[TB] FAIL %s: got grant=%b busy=%b idx=%0d evt=%b tidx=%0d, want grant=%b busy=%b idx=%0d evt=%b tidx=%0d",
                     name, grant, busy, grantIdx, timeoutEvt, timeoutIdx,
                     expGrant, expBusy, expIdx, expEvt, expTidx);
        end
    endtask

    initial begin
        int order[8];
        logic [6:0] r;
        checks = 0;
        fails  = 0;

        // Cycle table, starting from reset (rr_ptr=0). Each row: inputs, then outputs after the edge.
        addVec(7'b0010000, 7'b0000000, 1'b1, 7'b0010000, 1'b1, 3'd4);
        addVec(7'b0010000, 7'b0000000, 1'b1, 7'b0010000, 1'b1, 3'd4);
        addVec(7'b0010000, 7'b0000000, 1'b1, 7'b0010000, 1'b1, 3'd4);
        addVec(7'b0000000, 7'b0000000, 1'b1, 7'b0000000, 1'b0, 3'd0);
        addVec(7'b0000000, 7'b0000000, 1'b1, 7'b0000000, 1'b0, 3'd0);
        addVec(7'b0100011, 7'b0100000, 1'b1, 7'b0100000, 1'b1, 3'd5);
        addVec(7'b0000011, 7'b0100000, 1'b1, 7'b0000000, 1'b0, 3'd0);
        addVec(7'b0000011, 7'b0100000, 1'b1, 7'b0000000, 1'b0, 3'd0);
        addVec(7'b0000011, 7'b0100000, 1'b1, 7'b0000001, 1'b1, 3'd0);
        addVec(7'b0000010, 7'b0100000, 1'b1, 7'b0000000, 1'b0, 3'd0);
        addVec(7'b0000010, 7'b0100000, 1'b1, 7'b0000000, 1'b0, 3'd0);
        addVec(7'b0000010, 7'b0100000, 1'b1, 7'b0000010, 1'b1, 3'd1);
        addVec(7'b0000000, 7'b0000000, 1'b1, 7'b0000000, 1'b0, 3'd0);
        addVec(7'b0000000, 7'b0000000, 1'b1, 7'b0000000, 1'b0, 3'd0);
        addVec(7'b1000101, 7'b1000001, 1'b1, 7'b1000000, 1'b1, 3'd6);
        addVec(7'b0000000, 7'b1000001, 1'b1, 7'b0000000, 1'b0, 3'd0);
        addVec(7'b0000000, 7'b1000001, 1'b1, 7'b0000000, 1'b0, 3'd0);
        addVec(7'b1000101, 7'b1000001, 1'b1, 7'b0000001, 1'b1, 3'd0);
        addVec(7'b0000000, 7'b0000000, 1'b1, 7'b0000000, 1'b0, 3'd0);
        addVec(7'b0000000, 7'b0000000, 1'b1, 7'b0000000, 1'b0, 3'd0);
        addVec(7'b0000100, 7'b0000000, 1'b0, 7'b0000000, 1'b0, 3'd0);
        addVec(7'b0000100, 7'b0000000, 1'b1, 7'b0000100, 1'b1, 3'd2);
        addVec(7'b0000000, 7'b0000000, 1'b1, 7'b0000000, 1'b0, 3'd0);
        addVec(7'b0000000, 7'b0000000, 1'b1, 7'b0000000, 1'b0, 3'd0);

        rst = 1'b1;
        applyStimulus(7'b0, 7'b0, 1'b0);
        tick();
        tick();
        checkOutput("reset_values", 7'b0, 1'b0, 1'b1, 3'd0, 1'b0, 3'd0);
        rst = 1'b0;

        for (int i = 0; i < vecs.size(); i++) begin
            applyStimulus(vecs[i].req, vecs[i].hp, vecs[i].tx);
            tick();
            checkOutput($sformatf("table_row%0d", i), vecs[i].expGrant, vecs[i].expBusy,
                        vecs[i].expBusy, vecs[i].expIdx, 1'b0, 3'd0);
        end

        // Mid-frame reset (rr_ptr=3 here, so device 1 is the only candidate).
        applyStimulus(7'b0000010, 7'b0, 1'b1);
        tick();
        checkOutput("rst_pre_grant", 7'b0000010, 1'b1, 1'b1, 3'd1, 1'b0, 3'd0);
        rst = 1'b1;
        tick();
        checkOutput("rst_mid_frame", 7'b0, 1'b0, 1'b1, 3'd0, 1'b0, 3'd0);
        rst = 1'b0;
        applyStimulus(7'b0000110, 7'b0, 1'b1);
        tick();
        checkOutput("rst_ptr_cleared", 7'b0000010, 1'b1, 1'b1, 3'd1, 1'b0, 3'd0);
        applyStimulus(7'b0, 7'b0, 1'b1);
        tick();
        tick();

        // Round-robin from a fresh reset: every device requests, each frame lasts 3 cycles.
        rst = 1'b1;
        tick();
        rst = 1'b0;
        order = '{0, 1, 2, 3, 4, 5, 6, 0};
        r = 7'b1111111;
        applyStimulus(r, 7'b0, 1'b1);
        for (int n = 0; n < 8; n++) begin
            tick();
            checkOutput($sformatf("rr_grant%0d", n), 7'(1 << order[n]), 1'b1, 1'b1, 3'(order[n]), 1'b0, 3'd0);
            tick();
            tick();
            checkOutput($sformatf("rr_hold%0d", n), 7'(1 << order[n]), 1'b1, 1'b1, 3'(order[n]), 1'b0, 3'd0);
            r[order[n]] = 1'b0;
            applyStimulus(r, 7'b0, 1'b1);
            tick();
            checkOutput($sformatf("rr_gap%0d", n), 7'b0, 1'b0, 1'b0, 3'd0, 1'b0, 3'd0);
            r[order[n]] = 1'b1;
            applyStimulus(r, 7'b0, 1'b1);
            tick();
            checkOutput($sformatf("rr_idle%0d", n), 7'b0, 1'b0, 1'b0, 3'd0, 1'b0, 3'd0);
        end

        // tx_idle gating: 20 blocked cycles, then grant one cycle after tx_idle rises.
        applyStimulus(7'b0000100, 7'b0, 1'b0);
        for (int c = 0; c < 20; c++) begin
            tick();
            checkOutput($sformatf("txidle_blocked%0d", c), 7'b0, 1'b0, 1'b0, 3'd0, 1'b0, 3'd0);
        end
        applyStimulus(7'b0000100, 7'b0, 1'b1);
        tick();
        checkOutput("txidle_release", 7'b0000100, 1'b1, 1'b1, 3'd2, 1'b0, 3'd0);
        applyStimulus(7'b0, 7'b0, 1'b1);
        tick();
        tick();

        // Watchdog (TIMEOUT=8): 8 granted cycles, then revoke with a one-cycle event.
        applyStimulus(7'b0001000, 7'b0, 1'b1);
        tick();
        checkOutput("wd_grant", 7'b0001000, 1'b1, 1'b1, 3'd3, 1'b0, 3'd0);
        for (int c = 1; c < 8; c++) begin
            tick();
            checkOutput($sformatf("wd_hold%0d", c), 7'b0001000, 1'b1, 1'b1, 3'd3, 1'b0, 3'd0);
        end
        tick();
        checkOutput("wd_revoke", 7'b0, 1'b0, 1'b0, 3'd0, 1'b1, 3'd3);
        tick();
        checkOutput("wd_evt_pulse", 7'b0, 1'b0, 1'b0, 3'd0, 1'b0, 3'd3);
        for (int c = 0; c < 4; c++) begin
            tick();
            checkOutput($sformatf("wd_locked%0d", c), 7'b0, 1'b0, 1'b0, 3'd0, 1'b0, 3'd3);
        end
        applyStimulus(7'b0, 7'b0, 1'b1);
        tick();
        checkOutput("wd_drop", 7'b0, 1'b0, 1'b0, 3'd0, 1'b0, 3'd3);
        applyStimulus(7'b0001000, 7'b0, 1'b1);
        tick();
        checkOutput("wd_regrant", 7'b0001000, 1'b1, 1'b1, 3'd3, 1'b0, 3'd3);

        // Request falls in the very cycle the watchdog would fire: no timeout event.
        for (int c = 1; c < 8; c++) begin
            tick();
        end
        checkOutput("race_last_hold", 7'b0001000, 1'b1, 1'b1, 3'd3, 1'b0, 3'd3);
        applyStimulus(7'b0, 7'b0, 1'b1);
        tick();
        checkOutput("race_req_wins", 7'b0, 1'b0, 1'b0, 3'd0, 1'b0, 3'd3);
        tick();
        checkOutput("race_no_evt", 7'b0, 1'b0, 1'b0, 3'd0, 1'b0, 3'd3);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
